// File: rtl/wallace_pipelined_multiplier_if.sv
// wallace_pipelined_multiplier_if: operand/result handshake bundle for the pipelined Wallace multiplier.
// master drives operands and out_ready; slave (the multiplier) drives in_ready and the result.
interface wallace_pipelined_multiplier_if #(
    parameter int WIDTH = 4
);
    logic in_valid;
    logic in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic approx_en;
    logic out_valid;
    logic out_ready;
    logic [2*WIDTH-1:0] out;
    modport master (
        output in_valid, in1, in2, approx_en, out_ready,
        input in_ready, out_valid, out
    );
    modport slave (
        input in_valid, in1, in2, approx_en, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/wallace_pipelined_multiplier.sv
// wallace_pipelined_multiplier: STAGES-deep WIDTH x WIDTH unsigned Wallace multiplier with per-op approximate mode.
// Define MULT_STATS_EN to add saturating handshake counters stat_count and stat_approx.
module wallace_pipelined_multiplier #(
    parameter int WIDTH = 4,
    parameter int STAGES = 2,
    parameter int APPROX_COLS = 2
) (
    input  logic clk,
    input  logic rst,
    wallace_pipelined_multiplier_if.slave bus,
    output logic busy
`ifdef MULT_STATS_EN
    ,
    output logic [15:0] stat_count,
    output logic [15:0] stat_approx
`endif
);
    localparam int PW = 2 * WIDTH;
    typedef logic [WIDTH-1:0][PW-1:0] rows_t;

    function automatic int next_rows(int n);
        return 2 * (n / 3) + n % 3;
    endfunction

    function automatic int num_levels(int n);
        int l = 0;
        for (int i = 0; i < WIDTH; i++)
            if (n > 2) begin
                n = next_rows(n);
                l++;
            end
        return l;
    endfunction

    localparam int LEVELS = num_levels(WIDTH);

    // Reduction levels completed by the time an operation sits in stage register s.
    function automatic int cut(int s);
        return s == 0 ? 0 : s >= STAGES ? LEVELS : (LEVELS * s) / (STAGES - 1);
    endfunction

    // One Wallace level: every group of three rows becomes a sum row and a shifted carry row.
    function automatic rows_t csa_level(rows_t r, int n);
        rows_t o = '0;
        int g = n / 3;
        for (int k = 0; k < WIDTH / 3; k++)
            if (k < g) begin
                o[2*k]   = r[3*k] ^ r[3*k+1] ^ r[3*k+2];
                o[2*k+1] = ((r[3*k] & r[3*k+1]) | (r[3*k] & r[3*k+2]) | (r[3*k+1] & r[3*k+2])) << 1;
            end
        for (int k = 0; k < 2; k++)
            if (k < n % 3) o[2*g+k] = r[3*g+k];
        return o;
    endfunction

    function automatic rows_t reduce(rows_t r, int from, int to);
        int n = WIDTH;
        for (int l = 0; l < LEVELS; l++) begin
            if (l >= from && l < to) r = csa_level(r, n);
            n = next_rows(n);
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] cpa(rows_t r);
        return r[0] + r[1];
    endfunction

    rows_t pp;
    logic [PW-1:0] keep;
    always_comb begin
        keep = bus.approx_en ? ~((PW'(1) << APPROX_COLS) - PW'(1)) : '1;
        for (int j = 0; j < WIDTH; j++)
            pp[j] = (PW'(bus.in1 & {WIDTH{bus.in2[j]}}) << j) & keep;
    end

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] vnext;
    logic [PW-1:0] prod_q;
    logic adv;
    assign adv = !vld[STAGES-1] || bus.out_ready;
    assign vnext = (vld << 1) | STAGES'(bus.in_valid);
    assign bus.in_ready = adv;
    assign bus.out_valid = vld[STAGES-1];
    assign bus.out = prod_q;
    assign busy = |vld;

    rows_t stage_in [STAGES];
    assign stage_in[0] = pp;
    for (genvar s = 1; s < STAGES; s++) begin : g_stage
        rows_t q;
        always_ff @(posedge clk or posedge rst)
            if (rst) q <= '0;
            else if (adv) q <= reduce(stage_in[s-1], cut(s - 1), cut(s));
        assign stage_in[s] = q;
    end

    // The output register only loads behind a valid op so the last result lingers after its handshake.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            vld <= '0;
            prod_q <= '0;
        end else if (adv) begin
            vld <= vnext;
            if (vnext[STAGES-1]) prod_q <= cpa(reduce(stage_in[STAGES-1], cut(STAGES - 1), LEVELS));
        end

`ifdef MULT_STATS_EN
    logic [STAGES-1:0] ax;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ax <= '0;
            stat_count <= '0;
            stat_approx <= '0;
        end else begin
            if (adv) ax <= (ax << 1) | STAGES'(bus.approx_en);
            if (vld[STAGES-1] && bus.out_ready) begin
                if (stat_count != '1) stat_count <= stat_count + 16'd1;
                if (ax[STAGES-1] && stat_approx != '1) stat_approx <= stat_approx + 16'd1;
            end
        end
`endif
endmodule

// File: doc/wallace_pipelined_multiplier.md
Name: wallace_pipelined_multiplier

Overview:
- Parametrised, pipelined successor to the 4-bit combinational Wallace multiplier.
- Unsigned WIDTH x WIDTH multiply through Wallace-tree carry-save reduction, then a final carry-propagate adder.
- Registers split the datapath into STAGES cycles, with valid/ready handshakes on both sides.
- Supports a per-operation approximate mode that drops low partial-product columns; used as the building block for error/area studies of approximate multipliers.

Parameters:
- WIDTH, 4, operand width in bits; legal range 4..16.
- STAGES, 2, pipeline register stages (operand-to-result latency in cycles); legal range 1..4.
- APPROX_COLS, 2, number of low product columns whose partial products are discarded in approximate mode; legal range 0..WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts an operand pair this cycle.
- in1  input  WIDTH  multiplicand, unsigned.
- in2  input  WIDTH  multiplier, unsigned.
- approx_en  input  1  approximate mode for this operation; sampled with the operands.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- out  output  2*WIDTH  product.
- busy  output  1  at least one pipeline stage holds a valid operation.

Behaviour:
- Reset, asynchronous:
  - All stage valid bits, out_valid, out and busy go to 0.
  - in_ready is 1 after reset.
  - Reset mid-operation discards every in-flight operation; nothing is emitted afterwards.
- Acceptance: an operation is accepted on a rising edge with in_valid && in_ready.
- Result timing:
  - An accepted operation appears with out_valid=1 exactly STAGES cycles later when unstalled.
  - Results stay in order; no operation is dropped or duplicated.
- Stall:
  - The pipeline stalls as a whole when out_valid && !out_ready; every stage register holds.
  - in_ready = !out_valid || out_ready.
  - Bubbles are not compressed; a fully pipelined block is acceptable.
- Output hold: out and out_valid stay stable while stalled. out is unchanged (not cleared) after a handshake with no new result behind it.
- Throughput: one result per cycle with in_valid and out_ready held high.
- Simultaneous events: an output handshake and an input acceptance in the same cycle are both legal; all stages advance by one.
- Exact mode (approx_en=0): out = in1*in2, full 2*WIDTH bits, no truncation.
- Approximate mode (approx_en=1):
  - Partial product a_i&b_j is discarded when i+j < APPROX_COLS; all others are summed exactly.
  - out[APPROX_COLS-1:0] is therefore 0.
  - The result is never greater than the exact product.
  - APPROX_COLS=0 makes approximate mode identical to exact mode.
- Pipeline placement: Wallace reduction levels are distributed across stages 1..STAGES-1; the final carry-propagate adder sits in the last stage. approx_en travels with its operation.
- busy = OR of all stage valid bits, including the output stage.

Optional Feature:
- MULT_STATS_EN defined:
  - Adds output stat_count (16 bits): count of output handshakes.
  - Adds output stat_approx (16 bits): count of output handshakes whose operation had approx_en=1.
  - Both counters saturate at 16'hFFFF and clear on rst.
- MULT_STATS_EN undefined: neither port nor counter exists; the datapath is identical in both builds.

Test Plan:
- WIDTH=4, STAGES=2, out_ready=1; in1=4'b1010, in2=4'b1111, approx_en=0, one cycle -> out=8'd150 with out_valid high exactly 2 cycles after acceptance, for one cycle.
- Same operands, approx_en=1, APPROX_COLS=2 -> out=8'd148. Then 4'hF x 4'hF exact -> 8'd225.
- Back-to-back 0x0, 0xF x 0x1, 0x7 x 0x9, 0xF x 0xF, out_ready=1 -> results 0, 15, 63, 225 on 4 consecutive cycles.
- Hold out_ready=0 for 5 cycles with operands streaming:
  - -> in_ready drops once out_valid=1.
  - -> out stays stable through the stall.
  - -> after release, all results emerge in order with none lost.
- Assert rst for 1 cycle with 2 operations in flight -> out_valid, busy and out go to 0 immediately; no result is emitted afterwards.
- WIDTH=8, STAGES=3, 200 random operand pairs, approx_en random, random out_ready -> every result matches the exact or column-dropping reference model. With MULT_STATS_EN -> stat_count=200 and stat_approx equals the number of approx operations.
